jacobi_sweep_ctrl: RTL

//   Sequencer that drives the Jacobi eigen-decomposition of the covariance matrix.
//   It walks all off-diagonal pivot pairs (p,q) in cyclic row order, one sweep at a time.

---
 rtl/jacobi_sweep_ctrl_if.sv | 26 ++
 rtl/jacobi_sweep_ctrl.sv | 138 +++++++++++++
 2 files changed

// File: rtl/jacobi_sweep_ctrl_if.sv
// Rotation-unit handshake bundle for the Jacobi sweep sequencer.
//   rot_valid_out  controller -> rotation unit: request valid
//   rot_ready_in   rotation unit -> controller: request accepted
//   rot_p_out      controller -> rotation unit: pivot row p (p < q)
//   rot_q_out      controller -> rotation unit: pivot column q
//   rot_done_in    rotation unit -> controller: one-cycle write-back pulse
// master = sequencer side, slave = rotation unit side.
interface jacobi_sweep_ctrl_if #(
  parameter int IDX_W = 2
);
  logic             rot_valid_out;
  logic             rot_ready_in;
  logic [IDX_W-1:0] rot_p_out;
  logic [IDX_W-1:0] rot_q_out;
  logic             rot_done_in;

  modport master (
    output rot_valid_out, rot_p_out, rot_q_out,
    input  rot_ready_in, rot_done_in
  );

  modport slave (
    input  rot_valid_out, rot_p_out, rot_q_out,
    output rot_ready_in, rot_done_in
  );
endinterface

// File: rtl/jacobi_sweep_ctrl.sv
// Jacobi eigen-decomposition sequencer. Walks every off-diagonal pivot pair
// (p,q) in cyclic row order, one sweep at a time, handing each pair to the
// rotation unit. The convergence flag is sampled between sweeps; the run ends
// on convergence or when the sweep budget is used up.
// Ports:
//   clk_in         clock, rising edge
//   rst_in         synchronous active-high reset
//   start_in       begin a run (only looked at while idle)
//   conv_in        convergence flag of the current matrix
//   rot            rotation request/done handshake (master side)
//   busy_out       high whenever not idle
//   done_out       one-cycle pulse at the end of a run
//   converged_out  run result, held until the next start
//   sweeps_out     completed sweeps, held until the next start
//
// state    | meaning
// ---------+-------------------------------------------------------------
// S_IDLE   | waiting for start_in
// S_CHECK  | matrix stable; sample conv_in and the sweep budget
// S_ISSUE  | rot_valid_out high with (p,q) held until accepted
// S_WAIT   | request accepted; wait for rot_done_in, then advance pair
// S_FINISH | done_out pulse, back to idle
module jacobi_sweep_ctrl #(
  parameter int N_STOCKS   = 4,
  parameter int MAX_SWEEPS = 8,
  parameter int IDX_W      = (N_STOCKS > 1) ? $clog2(N_STOCKS) : 1,
  parameter int SWP_W      = $clog2(MAX_SWEEPS + 1)
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  start_in,
  input  logic                  conv_in,
  jacobi_sweep_ctrl_if.master   rot,
  output logic                  busy_out,
  output logic                  done_out,
  output logic                  converged_out,
  output logic [SWP_W-1:0]      sweeps_out
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CHECK  = 3'd1,
    S_ISSUE  = 3'd2,
    S_WAIT   = 3'd3,
    S_FINISH = 3'd4
  } state_t;

  localparam logic [IDX_W-1:0] Q_LAST    = IDX_W'(N_STOCKS - 1);
  localparam logic [IDX_W-1:0] P_LAST    = IDX_W'(N_STOCKS - 2);
  localparam logic [SWP_W-1:0] SWP_LIMIT = SWP_W'(MAX_SWEEPS);

  state_t           state, state_nxt;
  logic [IDX_W-1:0] p_q, p_nxt, p_inc;
  logic [IDX_W-1:0] q_q, q_nxt;
  logic [SWP_W-1:0] sweeps_q, sweeps_nxt;
  logic             conv_q, conv_nxt;

  assign p_inc = p_q + IDX_W'(1);

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state    <= S_IDLE;
      p_q      <= '0;
      q_q      <= IDX_W'(1);
      sweeps_q <= '0;
      conv_q   <= 1'b0;
    end else begin
      state    <= state_nxt;
      p_q      <= p_nxt;
      q_q      <= q_nxt;
      sweeps_q <= sweeps_nxt;
      conv_q   <= conv_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    p_nxt      = p_q;
    q_nxt      = q_q;
    sweeps_nxt = sweeps_q;
    conv_nxt   = conv_q;
    case (state)
      S_IDLE: begin
        if (start_in) begin
          state_nxt  = S_CHECK;
          sweeps_nxt = '0;
          conv_nxt   = 1'b0;
          p_nxt      = '0;
          q_nxt      = IDX_W'(1);
        end
      end
      S_CHECK: begin
        // Convergence wins over an exhausted budget on the final check.
        if (conv_in) begin
          conv_nxt  = 1'b1;
          state_nxt = S_FINISH;
        end else if (sweeps_q == SWP_LIMIT) begin
          conv_nxt  = 1'b0;
          state_nxt = S_FINISH;
        end else begin
          state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (rot.rot_ready_in) state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (rot.rot_done_in) begin
          if (q_q < Q_LAST) begin
            q_nxt     = q_q + IDX_W'(1);
            state_nxt = S_ISSUE;
          end else if (p_q < P_LAST) begin
            // Next row starts just right of the diagonal of the new p.
            p_nxt     = p_inc;
            q_nxt     = p_inc + IDX_W'(1);
            state_nxt = S_ISSUE;
          end else begin
            sweeps_nxt = sweeps_q + SWP_W'(1);
            p_nxt      = '0;
            q_nxt      = IDX_W'(1);
            state_nxt  = S_CHECK;
          end
        end
      end
      S_FINISH: state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  assign rot.rot_valid_out = (state == S_ISSUE);
  assign rot.rot_p_out     = p_q;
  assign rot.rot_q_out     = q_q;
  assign busy_out          = (state != S_IDLE);
  assign done_out          = (state == S_FINISH);
  assign converged_out     = conv_q;
  assign sweeps_out        = sweeps_q;

endmodule
